tap_ctrl_ir: RTL and testbench

TAP_CTRL_IR -- requirements
Module: tap_ctrl_ir

---
 rtl/tap_ctrl_ir.sv | 120 ++++++++++++
 tb/tb_tap_ctrl_ir.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tap_ctrl_ir.sv
// IEEE 1149.1 TAP controller with instruction register, IDCODE and bypass
// data registers, and strobes for an external boundary-scan register.
module tap_ctrl_ir #(
  parameter int                    IR_WIDTH   = 4,
  parameter logic [31:0]           IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]   OP_EXTEST  = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0]   OP_SAMPLE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]   OP_IDCODE  = IR_WIDTH'(2)
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_tdo,
  output logic                clockdr,
  output logic                shiftdr,
  output logic                updatedr,
  output logic                clockir,
  output logic                shiftir,
  output logic                updateir,
  output logic                select,
  output logic                bs_en,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] instr,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR  = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR  = 4'hD
  } state_t;

  state_t              state, state_nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         id_sr;
  logic                byp_sr;
  logic                sel_id, sel_bsr;

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms ? TLR    : RTI;
      RTI:      state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:   state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TLR;
    else      state <= state_nxt;
  end

  // instr is forced to IDCODE both while in TLR and on the edge entering it,
  // so a five-TMS=1 escape leaves IDCODE active as soon as TLR is reached.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr <= '0;
      instr <= OP_IDCODE;
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_WIDTH'(2'b01);
      else if (state == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (state == TLR || state_nxt == TLR) instr <= OP_IDCODE;
      else if (state == UPD_IR)             instr <= ir_sr;
    end
  end

  assign sel_id  = (instr == OP_IDCODE);
  assign sel_bsr = !sel_id && (instr == OP_EXTEST || instr == OP_SAMPLE);

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      id_sr  <= '0;
      byp_sr <= 1'b0;
    end else if (state == CAP_DR) begin
      if (sel_id)        id_sr  <= IDCODE_VAL | 32'd1;
      else if (!sel_bsr) byp_sr <= 1'b0;
    end else if (state == SH_DR) begin
      if (sel_id)        id_sr  <= {tdi, id_sr[31:1]};
      else if (!sel_bsr) byp_sr <= tdi;
    end
  end

  assign clockdr   = (state == CAP_DR) || (state == SH_DR);
  assign shiftdr   = (state == SH_DR);
  assign updatedr  = (state == UPD_DR);
  assign clockir   = (state == CAP_IR) || (state == SH_IR);
  assign shiftir   = (state == SH_IR);
  assign updateir  = (state == UPD_IR);
  assign select    = (state == SEL_IR) || (state == CAP_IR) || (state == SH_IR) ||
                     (state == EX1_IR) || (state == PAUSE_IR) || (state == EX2_IR) ||
                     (state == UPD_IR);
  assign tdo_en    = shiftdr || shiftir;
  assign bs_en     = (instr == OP_EXTEST);
  assign tap_state = state;

  always_comb begin
    tdo = 1'b0;
    if (shiftir)      tdo = ir_sr[0];
    else if (shiftdr) tdo = sel_id ? id_sr[0] : (sel_bsr ? bsr_tdo : byp_sr);
  end

endmodule

// File: tb/tb_tap_ctrl_ir.sv
// Bench for tap_ctrl_ir: directed walks through the TAP scenarios plus a
// random TMS/TDI phase, all checked against a table-driven reference model.
module tb_tap_ctrl_ir;
  localparam int          IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
  localparam logic [3:0]  EXT = 4'd0, SMP = 4'd1, IDC = 4'd2;

  // clock/reset block
  logic tck = 1'b0;
  logic trst = 1'b0;
  logic tms = 1'b1, tdi = 1'b0, bsr_tdo = 1'b0;
  always #5 tck = ~tck;

  logic clockdr, shiftdr, updatedr, clockir, shiftir, updateir;
  logic select, bs_en, tdo, tdo_en;
  logic [IRW-1:0] instr;
  logic [3:0]     tap_state;

  tap_ctrl_ir #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV), .OP_EXTEST(EXT),
                .OP_SAMPLE(SMP), .OP_IDCODE(IDC)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .bsr_tdo(bsr_tdo),
    .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
    .clockir(clockir), .shiftir(shiftir), .updateir(updateir),
    .select(select), .bs_en(bs_en), .tdo(tdo), .tdo_en(tdo_en),
    .instr(instr), .tap_state(tap_state)
  );

  // reference model: next-state tables indexed by state code
  int n0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int n1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  int             ms;
  logic [IRW-1:0] mir, minstr;
  logic [31:0]    mid;
  logic           mbyp;
  int checks = 0, passes = 0;

  task automatic model_reset();
    ms = 15; mir = '0; minstr = IDC; mid = '0; mbyp = 1'b0;
  endtask

  function automatic int dr_sel();
    if (minstr == IDC) return 0;
    if (minstr == EXT || minstr == SMP) return 1;
    return 2;
  endfunction

  task automatic model_edge(input bit t, input bit d);
    int s, ns, sel;
    s = ms; ns = t ? n1[s] : n0[s]; sel = dr_sel();
    if (s == 14) mir = 1;
    if (s == 10) mir = (mir >> 1) | (d ? 4'b1000 : 4'b0000);
    if (s == 13) minstr = mir;
    if (s == 6) begin
      if (sel == 0) mid = IDV | 32'd1;
      else if (sel == 2) mbyp = 1'b0;
    end
    if (s == 2) begin
      if (sel == 0) mid = (mid >> 1) | (d ? 32'h8000_0000 : 32'h0);
      else if (sel == 2) mbyp = d;
    end
    if (s == 15 || ns == 15) minstr = IDC;
    ms = ns;
  endtask

  function automatic logic exp_tdo();
    if (ms == 10) return mir[0];
    if (ms == 2) begin
      case (dr_sel())
        0:       return mid[0];
        1:       return bsr_tdo;
        default: return mbyp;
      endcase
    end
    return 1'b0;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("tap_state", tap_state, ms);
    chk("instr", instr, minstr);
    chk("tdo", tdo, exp_tdo());
    chk("tdo_en", tdo_en, (ms == 2 || ms == 10));
    chk("clockdr", clockdr, (ms == 6 || ms == 2));
    chk("shiftdr", shiftdr, (ms == 2));
    chk("updatedr", updatedr, (ms == 5));
    chk("clockir", clockir, (ms == 14 || ms == 10));
    chk("shiftir", shiftir, (ms == 10));
    chk("updateir", updateir, (ms == 13));
    chk("select", select, (ms inside {4, 14, 10, 9, 11, 8, 13}));
    chk("bs_en", bs_en, (minstr == EXT));
  endtask

  // driver tasks
  task automatic step(input bit t, input bit d);
    @(negedge tck);
    tms = t; tdi = d; bsr_tdo = 1'($urandom_range(0, 1));
    @(posedge tck);
    model_edge(t, d);
    #1;
    check_all();
  endtask

  task automatic pulse_rst();
    @(negedge tck);
    #2 trst = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_abort_state", tap_state, 4'hF);
    @(negedge tck);
    #2 trst = 1'b0;
  endtask

  logic [31:0] got;

  initial begin
    model_reset();
    #1 trst = 1'b1;
    #2 check_all();
    repeat (2) @(negedge tck);
    #1 check_all();
    #1 trst = 1'b0;

    // reset exit, walk to Capture-DR and Shift-DR
    step(0, 0); chk("rti_after_reset", tap_state, 4'hC);
    step(1, 0); step(0, 0); chk("capdr_clockdr", clockdr, 1'b1);
    step(0, 0); chk("shdr_shiftdr", shiftdr, 1'b1); chk("shdr_tdo_en", tdo_en, 1'b1);

    // IDCODE shifted out LSB-first
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo;
      step(i == 31, 1'($urandom_range(0, 1)));
    end
    chk("idcode_stream", got, IDV);

    // load all-ones (BYPASS) and check one-cycle bypass delay
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1); step(0, 1); step(1, 1);
    step(1, 0); step(0, 0); chk("bypass_instr", instr, 4'hF);
    step(1, 0); step(0, 0); step(0, 1); chk("bypass_first", tdo, 1'b0);
    step(0, 1); chk("bypass_second", tdo, 1'b1);
    step(0, 1); chk("bypass_third", tdo, 1'b1);
    step(1, 1);

    // IR capture pattern, then EXTEST and BSR pass-through
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("ir_cap_bit0", tdo, 1'b1);
    step(0, 0); chk("ir_cap_bit1", tdo, 1'b0);
    step(0, 0); step(0, 0); step(1, 0);
    step(1, 0); step(0, 0); chk("extest_bs_en", bs_en, 1'b1);
    step(1, 0); step(0, 0); step(0, 0); chk("bsr_pass0", tdo, bsr_tdo);
    step(0, 1); chk("bsr_pass1", tdo, bsr_tdo);

    // PauseIR then five TMS=1 edges back to TLR
    step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("in_pause_ir", tap_state, 4'hB);
    repeat (5) step(1, 0);
    chk("tlr5_state", tap_state, 4'hF);
    chk("tlr5_instr", instr, IDC);
    chk("tlr5_bs_en", bs_en, 1'b0);

    // async abort in Shift-DR and in Shift-IR
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    pulse_rst();
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 1);
    pulse_rst();
    chk("abort_instr", instr, IDC);

    // random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_rst();
      else step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
    end

    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
